// File: rtl/reg_file_bypass.sv
// Register file: GPR array plus T/SP/IH/RA, two prioritised write-back ports,
// same-cycle read bypass and a per-GPR busy scoreboard for in-flight loads.
module reg_file_bypass #(
  parameter int unsigned          DATA_W  = 16,
  parameter int unsigned          GPR_NUM = 8,
  parameter int unsigned          ADDR_W  = 3,
  parameter logic [DATA_W-1:0]    SP_RST  = '0
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [2:0]          wb0_op,
  input  logic [ADDR_W-1:0]   wb0_addr,
  input  logic [DATA_W-1:0]   wb0_data,
  input  logic [2:0]          wb1_op,
  input  logic [ADDR_W-1:0]   wb1_addr,
  input  logic [DATA_W-1:0]   wb1_data,
  input  logic                busy_set,
  input  logic [ADDR_W-1:0]   busy_addr,
  output logic [DATA_W-1:0]   a_data,
  output logic [DATA_W-1:0]   b_data,
  output logic                a_busy,
  output logic                b_busy,
  output logic [DATA_W-1:0]   t_data,
  output logic [DATA_W-1:0]   sp_data,
  output logic [DATA_W-1:0]   ih_data,
  output logic [DATA_W-1:0]   ra_data,
  output logic [GPR_NUM-1:0]  busy_vec,
  output logic                conflict
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_GPR = 3'd1,
    OP_T   = 3'd2,
    OP_SP  = 3'd3,
    OP_IH  = 3'd4,
    OP_RA  = 3'd5
  } wb_op_e;

  logic [DATA_W-1:0]  gpr_q [GPR_NUM];
  logic [DATA_W-1:0]  gpr_d [GPR_NUM];
  logic [DATA_W-1:0]  t_q, t_d;
  logic [DATA_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0]  ih_q, ih_d;
  logic [DATA_W-1:0]  ra_q, ra_d;
  logic [GPR_NUM-1:0] busy_q, busy_d;
  logic               conflict_q, conflict_d;

  logic [GPR_NUM-1:0] wb0_hit, wb1_hit;
  logic               spec_collide;

  function automatic logic [DATA_W-1:0] pick(input logic hit0, input logic [DATA_W-1:0] d0,
                                             input logic hit1, input logic [DATA_W-1:0] d1,
                                             input logic [DATA_W-1:0] stored);
    if (hit0)      return d0;
    else if (hit1) return d1;
    else           return stored;
  endfunction

  // Per-GPR write decode; addresses beyond GPR_NUM never match, so they are
  // naturally ignored for writes, busy updates, reads and collisions.
  always_comb begin
    wb0_hit = '0;
    wb1_hit = '0;
    for (int unsigned i = 0; i < GPR_NUM; i++) begin
      wb0_hit[i] = (wb0_op == OP_GPR) && (wb0_addr == ADDR_W'(i));
      wb1_hit[i] = (wb1_op == OP_GPR) && (wb1_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < GPR_NUM; i++) begin
      gpr_d[i] = pick(wb0_hit[i], wb0_data, wb1_hit[i], wb1_data, gpr_q[i]);
    end
    t_d  = pick(wb0_op == OP_T,  wb0_data, wb1_op == OP_T,  wb1_data, t_q);
    sp_d = pick(wb0_op == OP_SP, wb0_data, wb1_op == OP_SP, wb1_data, sp_q);
    ih_d = pick(wb0_op == OP_IH, wb0_data, wb1_op == OP_IH, wb1_data, ih_q);
    ra_d = pick(wb0_op == OP_RA, wb0_data, wb1_op == OP_RA, wb1_data, ra_q);
  end

  // Set is applied after clear so a load issued to a register being written
  // back in the same cycle stays pending.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < GPR_NUM; i++) begin
      if (wb0_hit[i] || wb1_hit[i]) busy_d[i] = 1'b0;
      if (busy_set && (busy_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    spec_collide = (wb0_op == wb1_op) &&
                   ((wb0_op == OP_T) || (wb0_op == OP_SP) ||
                    (wb0_op == OP_IH) || (wb0_op == OP_RA));
    conflict_d   = spec_collide || (|(wb0_hit & wb1_hit));
  end

  // The next-state values already encode WB0 > WB1 > stored, so the bypassed
  // read outputs are simply the next-state values.
  always_comb begin
    a_data = '0;
    b_data = '0;
    a_busy = 1'b0;
    b_busy = 1'b0;
    for (int unsigned i = 0; i < GPR_NUM; i++) begin
      if (a_addr == ADDR_W'(i)) begin
        a_data = gpr_d[i];
        a_busy = busy_q[i] && !(wb0_hit[i] || wb1_hit[i]);
      end
      if (b_addr == ADDR_W'(i)) begin
        b_data = gpr_d[i];
        b_busy = busy_q[i] && !(wb0_hit[i] || wb1_hit[i]);
      end
    end
  end

  assign t_data   = t_d;
  assign sp_data  = sp_d;
  assign ih_data  = ih_d;
  assign ra_data  = ra_d;
  assign busy_vec = busy_q;
  assign conflict = conflict_q;

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      for (int unsigned i = 0; i < GPR_NUM; i++) begin
        gpr_q[i] <= '0;
      end
      t_q        <= '0;
      sp_q       <= SP_RST;
      ih_q       <= '0;
      ra_q       <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      gpr_q      <= gpr_d;
      t_q        <= t_d;
      sp_q       <= sp_d;
      ih_q       <= ih_d;
      ra_q       <= ra_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed bench for reg_file_bypass: a target-level reference model checked
// every cycle, plus hand-computed literal checks along the directed sequence.
module tb_reg_file_bypass;

  localparam int unsigned DW = 16;
  localparam int unsigned GN = 8;
  localparam int unsigned AW = 3;

  logic          clk_50MHz = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [2:0]    wb0_op = '0, wb1_op = '0;
  logic [AW-1:0] wb0_addr = '0, wb1_addr = '0;
  logic [DW-1:0] wb0_data = '0, wb1_data = '0;
  logic          busy_set = 1'b0;
  logic [AW-1:0] busy_addr = '0;
  logic [DW-1:0] a_data, b_data, t_data, sp_data, ih_data, ra_data;
  logic          a_busy, b_busy, conflict;
  logic [GN-1:0] busy_vec;

  reg_file_bypass #(.DATA_W(DW), .GPR_NUM(GN), .ADDR_W(AW), .SP_RST(16'h00FF)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .a_addr(a_addr), .b_addr(b_addr),
    .wb0_op(wb0_op), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_op(wb1_op), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .a_data(a_data), .b_data(b_data), .a_busy(a_busy), .b_busy(b_busy),
    .t_data(t_data), .sp_data(sp_data), .ih_data(ih_data), .ra_data(ra_data),
    .busy_vec(busy_vec), .conflict(conflict)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers named by target id (0..7 GPR, 102..105 specials)
  logic [DW-1:0] m_gpr [GN];
  logic [DW-1:0] m_t, m_sp, m_ih, m_ra;
  logic [GN-1:0] m_busy;
  logic          m_conf;

  function automatic int target(input logic [2:0] op, input logic [AW-1:0] addr);
    if (op == 3'd1) return int'(addr);
    if (op >= 3'd2 && op <= 3'd5) return 100 + int'(op);
    return -1;
  endfunction

  function automatic logic [DW-1:0] m_value(input int tgt);
    if (tgt < 0) return '0;
    if (tgt < int'(GN)) return m_gpr[tgt];
    case (tgt)
      102: return m_t;
      103: return m_sp;
      104: return m_ih;
      default: return m_ra;
    endcase
  endfunction

  // What a reader sees this cycle: the winning write, else the stored value.
  function automatic logic [DW-1:0] m_view(input int tgt);
    if (tgt >= 0 && target(wb0_op, wb0_addr) == tgt) return wb0_data;
    if (tgt >= 0 && target(wb1_op, wb1_addr) == tgt) return wb1_data;
    return m_value(tgt);
  endfunction

  function automatic logic m_busy_view(input logic [AW-1:0] addr);
    int tgt = int'(addr);
    return m_busy[tgt] && (target(wb0_op, wb0_addr) != tgt) && (target(wb1_op, wb1_addr) != tgt);
  endfunction

  task automatic m_store(input int tgt, input logic [DW-1:0] d);
    if (tgt >= 0 && tgt < int'(GN)) m_gpr[tgt] = d;
    else if (tgt == 102) m_t = d;
    else if (tgt == 103) m_sp = d;
    else if (tgt == 104) m_ih = d;
    else if (tgt == 105) m_ra = d;
  endtask

  always @(posedge clk_50MHz) begin
    int t0, t1;
    t0 = target(wb0_op, wb0_addr);
    t1 = target(wb1_op, wb1_addr);
    if (!rst) begin
      for (int i = 0; i < int'(GN); i++) m_gpr[i] = '0;
      m_t = '0; m_sp = 16'h00FF; m_ih = '0; m_ra = '0;
      m_busy = '0; m_conf = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_conf = (t0 >= 0) && (t0 == t1);
      m_store(t1, wb1_data);
      m_store(t0, wb0_data);
      if (t0 >= 0 && t0 < int'(GN)) m_busy[t0] = 1'b0;
      if (t1 >= 0 && t1 < int'(GN)) m_busy[t1] = 1'b0;
      if (busy_set) m_busy[busy_addr] = 1'b1;
    end
  end

  always @(negedge clk_50MHz) begin
    if (chk_en) begin
      chk("a_data",   32'(a_data),   32'(m_view(int'(a_addr))));
      chk("b_data",   32'(b_data),   32'(m_view(int'(b_addr))));
      chk("a_busy",   32'(a_busy),   32'(m_busy_view(a_addr)));
      chk("b_busy",   32'(b_busy),   32'(m_busy_view(b_addr)));
      chk("t_data",   32'(t_data),   32'(m_view(102)));
      chk("sp_data",  32'(sp_data),  32'(m_view(103)));
      chk("ih_data",  32'(ih_data),  32'(m_view(104)));
      chk("ra_data",  32'(ra_data),  32'(m_view(105)));
      chk("busy_vec", 32'(busy_vec), 32'(m_busy));
      chk("conflict", 32'(conflict), 32'(m_conf));
    end
  end

  task automatic idle();
    wb0_op = 3'd0; wb1_op = 3'd0; busy_set = 1'b0;
  endtask

  task automatic wb0(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    wb0_op = op; wb0_addr = addr; wb0_data = d;
  endtask

  task automatic wb1(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    wb1_op = op; wb1_addr = addr; wb1_data = d;
  endtask

  // Inputs change 1 time unit after a rising edge; observe at the next falling edge.
  task automatic next_cycle();
    @(posedge clk_50MHz); #1;
  endtask

  task automatic observe();
    @(negedge clk_50MHz); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges with a GPR write pending
    rst = 1'b0; a_addr = 3'd1; b_addr = 3'd0;
    wb0(3'd1, 3'd1, 16'hDEAD);
    next_cycle(); next_cycle();
    rst = 1'b1; idle();
    observe();
    chk("rst_a_data",   32'(a_data),   32'h0);
    chk("rst_sp",       32'(sp_data),  32'h00FF);
    chk("rst_busy_vec", 32'(busy_vec), 32'h0);
    chk("rst_conflict", 32'(conflict), 32'h0);

    // Same-cycle bypass then stored value
    next_cycle(); wb0(3'd1, 3'd3, 16'hA5A5); a_addr = 3'd3;
    observe(); chk("bypass_a", 32'(a_data), 32'hA5A5);
    next_cycle(); idle();
    observe(); chk("stored_a", 32'(a_data), 32'hA5A5);

    // Dual write to distinct GPRs, then SP collision
    next_cycle(); wb0(3'd1, 3'd2, 16'h1111); wb1(3'd1, 3'd5, 16'h2222); a_addr = 3'd2; b_addr = 3'd5;
    observe();
    next_cycle(); wb0(3'd3, 3'd0, 16'h0010); wb1(3'd3, 3'd0, 16'h0020);
    observe();
    chk("dual_a", 32'(a_data), 32'h1111);
    chk("dual_b", 32'(b_data), 32'h2222);
    chk("dual_noconf", 32'(conflict), 32'h0);
    chk("sp_bypass", 32'(sp_data), 32'h0010);
    next_cycle(); idle();
    observe(); chk("sp_win", 32'(sp_data), 32'h0010); chk("conf_pulse", 32'(conflict), 32'h1);
    next_cycle();
    observe(); chk("conf_drop", 32'(conflict), 32'h0);

    // Scoreboard set, then load return through WB1
    next_cycle(); busy_set = 1'b1; busy_addr = 3'd4; a_addr = 3'd4; b_addr = 3'd4;
    observe();
    next_cycle(); idle();
    observe(); chk("busy4_set", 32'(busy_vec[4]), 32'h1); chk("a_busy4", 32'(a_busy), 32'h1);
    next_cycle(); wb1(3'd1, 3'd4, 16'hBEEF);
    observe(); chk("ret_a_busy", 32'(a_busy), 32'h0); chk("ret_a_data", 32'(a_data), 32'hBEEF);
    next_cycle(); idle();
    observe(); chk("busy4_clr", 32'(busy_vec[4]), 32'h0);

    // Set beats clear on the same GPR
    next_cycle(); busy_set = 1'b1; busy_addr = 3'd6; wb0(3'd1, 3'd6, 16'h0606);
    observe();
    next_cycle(); idle();
    observe(); chk("set_beats_clr", 32'(busy_vec[6]), 32'h1);

    // GPR collision, distinct specials, and NOP encodings 6/7
    next_cycle(); wb0(3'd1, 3'd7, 16'h7070); wb1(3'd1, 3'd7, 16'h7171); b_addr = 3'd7;
    observe(); chk("gpr_coll_b", 32'(b_data), 32'h7070);
    next_cycle(); wb0(3'd4, 3'd0, 16'h4444); wb1(3'd5, 3'd0, 16'h5555);
    observe(); chk("gpr_coll_conf", 32'(conflict), 32'h1);
    next_cycle(); wb0(3'd6, 3'd7, 16'hFFFF); wb1(3'd7, 3'd7, 16'hEEEE);
    observe();
    chk("spec_noconf", 32'(conflict), 32'h0);
    chk("nop_b", 32'(b_data), 32'h7070);
    chk("ih", 32'(ih_data), 32'h4444);
    chk("ra", 32'(ra_data), 32'h5555);
    next_cycle(); idle();
    observe(); chk("nop_noconf", 32'(conflict), 32'h0);

    // Build busy_vec=8'h30 and T=1234, then reset alongside a T write
    next_cycle(); busy_set = 1'b1; busy_addr = 3'd4; wb0(3'd1, 3'd6, 16'h0666);
    observe();
    next_cycle(); busy_addr = 3'd5; wb0(3'd2, 3'd0, 16'h1234);
    observe();
    next_cycle(); idle();
    observe(); chk("pre_busy", 32'(busy_vec), 32'h30); chk("pre_t", 32'(t_data), 32'h1234);
    next_cycle(); rst = 1'b0; wb0(3'd2, 3'd0, 16'h5555);
    observe();
    next_cycle(); rst = 1'b1; idle();
    observe();
    chk("mid_rst_t", 32'(t_data), 32'h0);
    chk("mid_rst_busy", 32'(busy_vec), 32'h0);
    chk("mid_rst_sp", 32'(sp_data), 32'h00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
